// File: rtl/lcd_capture_pkg.sv
// Shared constants, capture state encoding and byte-packing helpers for the LCD capture block.
package lcd_capture_pkg;

  localparam logic [7:0] LCD_W              = 8'd160;
  localparam logic [7:0] LCD_H              = 8'd144;
  localparam logic [7:0] LCD_BYTES_PER_LINE = 8'd40;

  typedef enum logic [1:0] {
    StWaitVsync = 2'd0,
    StActive    = 2'd1,
    StDrop      = 2'd2
  } cap_state_e;

  // y*40 as two shifts; 13 bits holds 143*40 without truncation.
  function automatic logic [12:0] line_base(input logic [7:0] y);
    return ({5'd0, y} << 5) + ({5'd0, y} << 3);
  endfunction

  // Left-justify the last n pixels of the pack register, padding with shade 0.
  function automatic logic [7:0] pad_byte(input logic [7:0] pack, input logic [1:0] n);
    logic [7:0] res;
    case (n)
      2'd1:    res = {pack[1:0], 6'd0};
      2'd2:    res = {pack[3:0], 4'd0};
      2'd3:    res = {pack[5:0], 2'd0};
      default: res = pack;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous level so pulse- and level-style markers both work.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_i;
    end
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/lcd_capture.sv
// Captures a 160x144 DMG pixel stream into a double-buffered 2bpp framebuffer.
module lcd_capture
  import lcd_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_vsync,
  input  logic        lcd_hsync,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  input  logic        err_clr,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  output logic        fb_bank,
  output logic        frame_done,
  output logic        err_overrun,
  output logic        err_frame
);

  logic vs_rise, hs_rise;

  rise_detect u_vs_rise (
    .clk     (clk),
    .rst     (rst),
    .level_i (lcd_vsync),
    .rise_o  (vs_rise)
  );

  rise_detect u_hs_rise (
    .clk     (clk),
    .rst     (rst),
    .level_i (lcd_hsync),
    .rise_o  (hs_rise)
  );

  cap_state_e  state_q, state_d, state_eff;
  logic [7:0]  x_q, x_d, x_eff;
  logic [7:0]  y_q, y_d;
  logic [7:0]  pack_q, pack_d, pack_eff;
  logic        wbank_q, wbank_d;
  logic        fb_bank_q, fb_bank_d;
  logic        we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d, ovr_set;
  logic        frm_q, frm_d, frm_set;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pack_d    = pack_q;
    wbank_d   = wbank_q;
    fb_bank_d = fb_bank_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ovr_set   = 1'b0;
    frm_set   = 1'b0;
    state_eff = state_q;
    x_eff     = x_q;
    pack_eff  = pack_q;

    if (vs_rise) begin
      // Vsync overrides everything else in this cycle, including a coincident pixel.
      frm_set = (state_q != StWaitVsync);
      state_d = StActive;
      x_d     = 8'd0;
      y_d     = 8'd0;
      pack_d  = 8'd0;
    end else if (state_q != StWaitVsync) begin
      if (lcd_pixel && state_q == StActive) begin
        if (x_q == LCD_W) begin
          ovr_set   = 1'b1;
          state_eff = StDrop;
        end else begin
          pack_eff = {pack_q[5:0], lcd_color};
          x_eff    = x_q + 8'd1;
          if (x_q[1:0] == 2'd3) begin
            we_d   = 1'b1;
            data_d = pack_eff;
            addr_d = {wbank_q, line_base(y_q) + {7'd0, x_q[7:2]}};
          end
        end
      end
      state_d = state_eff;
      x_d     = x_eff;
      pack_d  = pack_eff;

      // Hsync sees the line including any pixel from this same cycle.
      if (hs_rise) begin
        if (x_eff != 8'd0 && x_eff < LCD_W && x_eff[1:0] != 2'd0) begin
          we_d   = 1'b1;
          data_d = pad_byte(pack_eff, x_eff[1:0]);
          addr_d = {wbank_q, line_base(y_q) + {7'd0, x_eff[7:2]}};
        end
        x_d     = 8'd0;
        state_d = StActive;
        if (y_q == LCD_H - 8'd1) begin
          y_d       = 8'd0;
          fb_bank_d = wbank_q;
          wbank_d   = ~wbank_q;
          done_d    = 1'b1;
          state_d   = StWaitVsync;
        end else begin
          y_d = y_q + 8'd1;
        end
      end
    end

    ovr_d = ovr_set | (ovr_q & ~err_clr);
    frm_d = frm_set | (frm_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StWaitVsync;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      pack_q    <= 8'd0;
      wbank_q   <= 1'b0;
      fb_bank_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 14'd0;
      data_q    <= 8'd0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pack_q    <= pack_d;
      wbank_q   <= wbank_d;
      fb_bank_q <= fb_bank_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      frm_q     <= frm_d;
    end
  end

  assign fb_addr     = addr_q;
  assign fb_data     = data_q;
  assign fb_we       = we_q;
  assign fb_bank     = fb_bank_q;
  assign frame_done  = done_q;
  assign err_overrun = ovr_q;
  assign err_frame   = frm_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Randomized and directed bench for lcd_capture against a line-buffer reference model.
module tb_lcd_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lcd_vsync = 1'b0;
  logic        lcd_hsync = 1'b0;
  logic        lcd_pixel = 1'b0;
  logic [1:0]  lcd_color = 2'd0;
  logic        err_clr = 1'b0;
  logic [13:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        fb_bank;
  logic        frame_done;
  logic        err_overrun;
  logic        err_frame;

  always #5 clk = ~clk;

  lcd_capture dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_vsync   (lcd_vsync),
    .lcd_hsync   (lcd_hsync),
    .lcd_pixel   (lcd_pixel),
    .lcd_color   (lcd_color),
    .err_clr     (err_clr),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .fb_bank     (fb_bank),
    .frame_done  (frame_done),
    .err_overrun (err_overrun),
    .err_frame   (err_frame)
  );

  // Reference model: phase 0 = waiting for frame, 1 = capturing, 2 = dropping rest of line.
  int  m_phase, m_y, m_wbank, m_fbbank;
  int  pix[$];
  bit  m_prev_vs, m_prev_hs, m_ovr, m_frm;
  bit  e_we, e_done;
  int  e_addr, e_data;

  int  n_checks = 0;
  int  n_fail = 0;
  int  n_wr = 0;
  int  n_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pack_pixels(input int idx, input int n);
    int b = 0;
    for (int i = 0; i < n; i++) b += pix[idx + i] << (6 - 2 * i);
    return b;
  endfunction

  task automatic emit(input int group, input int data);
    e_we   = 1'b1;
    e_addr = m_wbank * 8192 + m_y * 40 + group;
    e_data = data;
  endtask

  task automatic model_step(input bit r, input bit v, input bit h, input bit p,
                            input bit [1:0] c, input bit clr);
    bit vr, hr, ovr_set, frm_set;
    int n;
    e_we = 1'b0;
    e_done = 1'b0;
    ovr_set = 1'b0;
    frm_set = 1'b0;
    if (!r) begin
      m_phase = 0; m_y = 0; m_wbank = 0; m_fbbank = 1;
      pix.delete();
      m_prev_vs = 1'b0; m_prev_hs = 1'b0; m_ovr = 1'b0; m_frm = 1'b0;
      e_addr = 0; e_data = 0;
      return;
    end
    vr = v && !m_prev_vs;
    hr = h && !m_prev_hs;
    m_prev_vs = v;
    m_prev_hs = h;
    if (vr) begin
      if (m_phase != 0) frm_set = 1'b1;
      m_phase = 1;
      m_y = 0;
      pix.delete();
    end else if (m_phase != 0) begin
      if (p && m_phase == 1) begin
        if (pix.size() == 160) begin
          ovr_set = 1'b1;
          m_phase = 2;
        end else begin
          pix.push_back(int'(c));
          if (pix.size() % 4 == 0) emit(pix.size() / 4 - 1, pack_pixels(pix.size() - 4, 4));
        end
      end
      if (hr) begin
        n = pix.size();
        if (n % 4 != 0) emit(n / 4, pack_pixels(n - n % 4, n % 4));
        pix.delete();
        m_phase = 1;
        if (m_y == 143) begin
          m_fbbank = m_wbank;
          m_wbank ^= 1;
          e_done = 1'b1;
          m_phase = 0;
          m_y = 0;
        end else begin
          m_y++;
        end
      end
    end
    m_ovr = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    m_frm = frm_set ? 1'b1 : (clr ? 1'b0 : m_frm);
  endtask

  task automatic tick(input bit r, input bit v, input bit h, input bit p,
                      input bit [1:0] c, input bit clr);
    @(negedge clk);
    rst = r; lcd_vsync = v; lcd_hsync = h; lcd_pixel = p; lcd_color = c; err_clr = clr;
    model_step(r, v, h, p, c, clr);
    @(posedge clk);
    #1;
    check_eq("fb_we", fb_we, e_we);
    if (e_we || !r) begin
      check_eq("fb_addr", fb_addr, e_addr);
      check_eq("fb_data", fb_data, e_data);
    end
    check_eq("frame_done", frame_done, e_done);
    check_eq("fb_bank", fb_bank, m_fbbank);
    check_eq("err_overrun", err_overrun, m_ovr);
    check_eq("err_frame", err_frame, m_frm);
    if (fb_we === 1'b1) n_wr++;
    if (frame_done === 1'b1) n_done++;
  endtask

  task automatic vsync_pulse();
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
  endtask

  // mode < 0: shades 0,1,2,3 repeating; otherwise a constant shade.
  task automatic send_line(input int n, input int mode);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 1, (mode < 0) ? 2'(i % 4) : 2'(mode), 0);
    tick(1, 0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
  endtask

  int w0, d0;

  initial begin
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // Two full frames of the repeating pattern, landing in bank 0 then bank 1.
    for (int f = 0; f < 2; f++) begin
      w0 = n_wr;
      d0 = n_done;
      vsync_pulse();
      for (int l = 0; l < 144; l++) send_line(160, -1);
      check_eq("frame_writes", n_wr - w0, 5760);
      check_eq("frame_done_count", n_done - d0, 1);
      check_eq("frame_bank", fb_bank, f);
    end

    vsync_pulse();
    w0 = n_wr;
    send_line(161, -1);
    check_eq("overrun_flag", err_overrun, 1);
    check_eq("overrun_writes", n_wr - w0, 40);
    send_line(6, 3);
    tick(1, 0, 0, 0, 0, 1);
    check_eq("overrun_cleared", err_overrun, 0);

    // Last pixel of a full line coincides with the hsync edge.
    for (int i = 0; i < 159; i++) tick(1, 0, 0, 1, 2'(i % 4), 0);
    tick(1, 0, 1, 1, 3, 0);
    tick(1, 0, 0, 0, 0, 0);
    for (int l = 0; l < 8; l++) send_line(8, l % 4);
    vsync_pulse();
    check_eq("frame_err", err_frame, 1);
    send_line(4, 2);

    // Vsync edge and pixel together: the pixel must vanish.
    tick(1, 1, 0, 1, 3, 0);
    tick(1, 0, 0, 0, 0, 1);
    send_line(5, -1);

    // Reset mid-frame abandons the frame.
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(20, -1);
    for (int i = 0; i < 10; i++) tick(1, 0, 0, 1, 1, 0);
    d0 = n_done;
    w0 = n_wr;
    tick(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 12; i++) tick(1, 0, (i == 6), 1, 2'(i % 4), 0);
    check_eq("reset_no_writes", n_wr - w0, 0);
    check_eq("reset_no_done", n_done - d0, 0);

    for (int k = 0; k < 70; k++) begin
      int r, n;
      r = $urandom_range(0, 99);
      if (r < 10) tick(1, 1, 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)), 0);
      else if (r < 12) tick(0, 0, 0, 0, 0, 0);
      n = $urandom_range(0, 165);
      for (int i = 0; i < n; i++)
        tick(1, 0, 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 29) == 0);
      tick(1, 0, 1, $urandom_range(0, 1), 2'($urandom_range(0, 3)), 0);
      tick(1, 0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
